// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per clock, 32 iterations.
// Result is {remainder, quotient}; the requester holds start_i until ready_o is seen.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StDivZero = 2'd1;
  localparam logic [1:0] StOn      = 2'd2;
  localparam logic [1:0] StEnd     = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic [31:0] partRem_q,  partRem_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q,  divisor_d;
  logic        signQuot_q, signQuot_d;
  logic        signRem_q,  signRem_d;
  logic [4:0]  count_q,    count_d;
  logic [63:0] result_q,   result_d;
  logic        ready_q,    ready_d;

  logic [31:0] absA, absB;
  logic [32:0] shifted, trialDiff;
  logic        qBit;
  logic [31:0] nextRem, nextQuot, finalRem, finalQuot;

  assign absA = (signed_div_i && a[31]) ? -a : a;
  assign absB = (signed_div_i && b[31]) ? -b : b;

  // The dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom.
  assign shifted   = {partRem_q, dividend_q[31]};
  assign trialDiff = shifted - {1'b0, divisor_q};
  assign qBit      = ~trialDiff[32];
  assign nextRem   = qBit ? trialDiff[31:0] : shifted[31:0];
  assign nextQuot  = {dividend_q[30:0], qBit};
  assign finalRem  = signRem_q  ? -nextRem  : nextRem;
  assign finalQuot = signQuot_q ? -nextQuot : nextQuot;

  always_comb begin
    state_d    = state_q;
    partRem_d  = partRem_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signQuot_d = signQuot_q;
    signRem_d  = signRem_q;
    count_d    = count_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      StIdle: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (b == '0) begin
            state_d = StDivZero;
          end else begin
            state_d    = StOn;
            dividend_d = absA;
            divisor_d  = absB;
            signQuot_d = signed_div_i & (a[31] ^ b[31]);
            signRem_d  = signed_div_i & a[31];
            count_d    = '0;
            partRem_d  = '0;
          end
        end
      end
      StDivZero: begin
        result_d = '0;
        if (annul_i) begin
          state_d = StIdle;
          ready_d = 1'b0;
        end else begin
          state_d = StEnd;
          ready_d = 1'b1;
        end
      end
      StOn: begin
        if (annul_i) begin
          state_d  = StIdle;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          partRem_d  = nextRem;
          dividend_d = nextQuot;
          count_d    = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d  = StEnd;
            result_d = {finalRem, finalQuot};
            ready_d  = 1'b1;
          end
        end
      end
      StEnd: begin
        if (!start_i) begin
          state_d  = StIdle;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      partRem_q  <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      signQuot_q <= 1'b0;
      signRem_q  <= 1'b0;
      count_q    <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      partRem_q  <= partRem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signQuot_q <= signQuot_d;
      signRem_q  <= signRem_d;
      count_q    <= count_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter: latency, signed/unsigned arithmetic, divide by zero,
// annul, mid-operation reset and the back-to-back handshake.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] a;
  logic [31:0] b;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks;
  int failures;

  div_iter dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .a            (a),
    .b            (b),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Raises start with the given operands and waits (bounded) for ready_o; start stays high.
  task automatic runOp(input logic sgn, input logic [31:0] opA, input logic [31:0] opB,
                       output int edges, output logic [63:0] res);
    signed_div_i = sgn;
    a            = opA;
    b            = opB;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    edges        = 0;
    do begin
      stepEdge();
      edges++;
    end while (!ready_o && edges < 40);
    res = result_o;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    a = '0;
    b = '0;
    stepEdge();
    stepEdge();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ready=%b result=%h exp ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b0;
    stepEdge();
  endtask

  task automatic test_unsigned();
    int edges;
    logic [63:0] res;
    runOp(1'b0, 32'd100, 32'd7, edges, res);
    checks++;
    if (edges !== 33) begin
      failures++;
      $display("[TB] FAIL udiv_100_7_latency got=%0d exp=33", edges);
    end
    checks++;
    if (res !== 64'h00000002_0000000E) begin
      failures++;
      $display("[TB] FAIL udiv_100_7_result got=%h exp=%h", res, 64'h00000002_0000000E);
    end
    start_i = 1'b0;
    stepEdge();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++;
      $display("[TB] FAIL udiv_drop_start got ready=%b result=%h exp ready=0 result=0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    int edges;
    logic [63:0] res;
    runOp(1'b1, 32'hFFFFFFF9, 32'd2, edges, res);
    checks++;
    if (res !== 64'hFFFFFFFF_FFFFFFFD || edges !== 33) begin
      failures++;
      $display("[TB] FAIL sdiv_m7_2 got=%h edges=%0d exp=%h edges=33", res, edges, 64'hFFFFFFFF_FFFFFFFD);
    end
    start_i = 1'b0;
    stepEdge();
    runOp(1'b1, 32'd7, 32'hFFFFFFFE, edges, res);
    checks++;
    if (res !== 64'h00000001_FFFFFFFD) begin
      failures++;
      $display("[TB] FAIL sdiv_7_m2 got=%h exp=%h", res, 64'h00000001_FFFFFFFD);
    end
    start_i = 1'b0;
    stepEdge();
  endtask

  task automatic test_divzero();
    int edges;
    logic [63:0] res;
    runOp(1'b0, 32'd5, 32'd0, edges, res);
    checks++;
    if (edges !== 2 || res !== 64'h0) begin
      failures++;
      $display("[TB] FAIL udiv_by_zero got edges=%0d result=%h exp edges=2 result=0", edges, res);
    end
    start_i = 1'b0;
    stepEdge();
    runOp(1'b1, 32'hFFFFFFFB, 32'd0, edges, res);
    checks++;
    if (edges !== 2 || res !== 64'h0) begin
      failures++;
      $display("[TB] FAIL sdiv_by_zero got edges=%0d result=%h exp edges=2 result=0", edges, res);
    end
    start_i = 1'b0;
    stepEdge();
  endtask

  task automatic test_divzero_annul();
    int readySeen;
    signed_div_i = 1'b0;
    a = 32'd5;
    b = 32'd0;
    start_i = 1'b1;
    annul_i = 1'b0;
    stepEdge();
    start_i = 1'b0;
    annul_i = 1'b1;
    readySeen = 0;
    for (int i = 0; i < 5; i++) begin
      stepEdge();
      if (ready_o) readySeen++;
    end
    annul_i = 1'b0;
    checks++;
    if (readySeen !== 0) begin
      failures++;
      $display("[TB] FAIL divzero_annul ready cycles got=%0d exp=0", readySeen);
    end
  endtask

  task automatic test_boundary();
    int edges;
    logic [63:0] res;
    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, edges, res);
    checks++;
    if (res !== 64'h00000000_80000000) begin
      failures++;
      $display("[TB] FAIL sdiv_min_m1 got=%h exp=%h", res, 64'h00000000_80000000);
    end
    start_i = 1'b0;
    stepEdge();
    runOp(1'b0, 32'hFFFFFFFF, 32'h00010000, edges, res);
    checks++;
    if (res !== 64'h0000FFFF_0000FFFF) begin
      failures++;
      $display("[TB] FAIL udiv_max_64k got=%h exp=%h", res, 64'h0000FFFF_0000FFFF);
    end
    start_i = 1'b0;
    stepEdge();
    runOp(1'b0, 32'hFFFFFFFF, 32'd1, edges, res);
    checks++;
    if (res !== 64'h00000000_FFFFFFFF) begin
      failures++;
      $display("[TB] FAIL udiv_max_1 got=%h exp=%h", res, 64'h00000000_FFFFFFFF);
    end
    start_i = 1'b0;
    stepEdge();
  endtask

  task automatic test_annul();
    int readySeen;
    int edges;
    logic [63:0] res;
    signed_div_i = 1'b0;
    a = 32'd1000;
    b = 32'd3;
    start_i = 1'b1;
    annul_i = 1'b0;
    stepEdge();
    for (int i = 0; i < 9; i++) stepEdge();
    annul_i = 1'b1;
    start_i = 1'b0;
    stepEdge();
    annul_i = 1'b0;
    readySeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) readySeen++;
      stepEdge();
    end
    checks++;
    if (readySeen !== 0) begin
      failures++;
      $display("[TB] FAIL annul_no_ready ready cycles got=%0d exp=0", readySeen);
    end
    runOp(1'b0, 32'd9, 32'd3, edges, res);
    checks++;
    if (edges !== 33 || res !== 64'h00000000_00000003) begin
      failures++;
      $display("[TB] FAIL after_annul_9_3 got edges=%0d result=%h exp edges=33 result=%h", edges, res, 64'h3);
    end
    start_i = 1'b0;
    stepEdge();
  endtask

  task automatic test_reset_mid();
    int readySeen;
    int edges;
    logic [63:0] res;
    signed_div_i = 1'b0;
    a = 32'd1000;
    b = 32'd3;
    start_i = 1'b1;
    annul_i = 1'b0;
    stepEdge();
    for (int i = 0; i < 19; i++) stepEdge();
    rst = 1'b1;
    start_i = 1'b0;
    stepEdge();
    rst = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs got ready=%b result=%h exp ready=0 result=0", ready_o, result_o);
    end
    readySeen = 0;
    for (int i = 0; i < 20; i++) begin
      stepEdge();
      if (ready_o) readySeen++;
    end
    checks++;
    if (readySeen !== 0) begin
      failures++;
      $display("[TB] FAIL reset_mid_abort ready cycles got=%0d exp=0", readySeen);
    end
    // Second run: operands and mode change right after acceptance must not matter.
    signed_div_i = 1'b0;
    a = 32'd50;
    b = 32'd5;
    start_i = 1'b1;
    stepEdge();
    a = 32'hFFFFFF85;
    b = 32'd7;
    signed_div_i = 1'b1;
    edges = 1;
    while (!ready_o && edges < 40) begin
      stepEdge();
      edges++;
    end
    res = result_o;
    checks++;
    if (edges !== 33 || res !== 64'h00000000_0000000A) begin
      failures++;
      $display("[TB] FAIL latched_50_5 got edges=%0d result=%h exp edges=33 result=%h", edges, res, 64'hA);
    end
    start_i = 1'b0;
    stepEdge();
  endtask

  task automatic test_back_to_back();
    int edges;
    int holdBad;
    logic [63:0] res;
    runOp(1'b0, 32'd100, 32'd7, edges, res);
    holdBad = 0;
    annul_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepEdge();
      if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) holdBad++;
    end
    annul_i = 1'b0;
    checks++;
    if (holdBad !== 0) begin
      failures++;
      $display("[TB] FAIL end_hold bad cycles got=%0d exp=0", holdBad);
    end
    start_i = 1'b0;
    stepEdge();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++;
      $display("[TB] FAIL b2b_idle got ready=%b result=%h exp ready=0 result=0", ready_o, result_o);
    end
    runOp(1'b1, 32'hFFFFFF9C, 32'd7, edges, res);
    checks++;
    if (edges !== 33 || res !== 64'hFFFFFFFE_FFFFFFF2) begin
      failures++;
      $display("[TB] FAIL b2b_second got edges=%0d result=%h exp edges=33 result=%h", edges, res, 64'hFFFFFFFE_FFFFFFF2);
    end
    start_i = 1'b0;
    stepEdge();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_divzero_annul();
    test_boundary();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
